lsu_mem_port: RTL and testbench

Load/store initiator driving the single-port word-addressed data memory (`we`/`addr`/`write_data`/`read_data`, write on posedge, combinational read). Accepts RV32 byte/half/word loads and stores from the CPU over a valid/ready request/response handshake. Sub-word stores are done as a read-modify-write. Misaligned and out-of-range accesses are detected and returned as errors.

---
 rtl/lsu_pkg.sv | 55 +++++
 rtl/lsu_mem_port_align.sv | 33 +++
 rtl/lsu_mem_port.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_port.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and lane helpers for the load/store memory port.
package lsu_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned F3_WIDTH = 3;
   localparam int unsigned OFF_W    = 2;
   localparam int unsigned LANES    = XLEN / 8;

   localparam logic [F3_WIDTH-1:0] F3_B  = 3'b000;
   localparam logic [F3_WIDTH-1:0] F3_H  = 3'b001;
   localparam logic [F3_WIDTH-1:0] F3_W  = 3'b010;
   localparam logic [F3_WIDTH-1:0] F3_BU = 3'b100;
   localparam logic [F3_WIDTH-1:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } lsu_state_t;

   // Request fields kept for the lifetime of one transaction.
   typedef struct packed {
      logic                store;
      logic [F3_WIDTH-1:0] funct3;
      logic [OFF_W-1:0]    off;
      logic [XLEN-1:0]     wdata;
   } lsu_req_t;

   function automatic logic [LANES-1:0] byte_mask(input logic [F3_WIDTH-1:0] funct3,
                                                  input logic [OFF_W-1:0]    off);
      case (funct3)
         F3_B, F3_BU: return 4'b0001 << off;
         F3_H, F3_HU: return 4'b0011 << {off[1], 1'b0};
         default:     return 4'b1111;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0]     word,
                                                   input logic [F3_WIDTH-1:0] funct3,
                                                   input logic [OFF_W-1:0]    off);
      logic [XLEN-1:0] byte_sh;
      logic [XLEN-1:0] half_sh;
      byte_sh = word >> {off, 3'b000};
      half_sh = word >> {off[1], 4'b0000};
      case (funct3)
         F3_B:    return {{24{byte_sh[7]}}, byte_sh[7:0]};
         F3_BU:   return {24'd0, byte_sh[7:0]};
         F3_H:    return {{16{half_sh[15]}}, half_sh[15:0]};
         F3_HU:   return {16'd0, half_sh[15:0]};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_port_align.sv
// Lane alignment: load extract/extend and sub-word store merge into the old word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0]     word,
   input  logic [F3_WIDTH-1:0] funct3,
   input  logic [OFF_W-1:0]    off,
   input  logic [XLEN-1:0]     wdata,
   output logic [XLEN-1:0]     load_data_c,
   output logic [XLEN-1:0]     merge_data_c
);

   logic [LANES-1:0] mask;
   logic [XLEN-1:0]  lanes;
   logic [XLEN-1:0]  bit_mask;

   // Store data is replicated across lanes, then the byte mask picks the live ones.
   always_comb begin
      mask     = byte_mask(funct3, off);
      bit_mask = '0;
      case (funct3)
         F3_B:    lanes = {4{wdata[7:0]}};
         F3_H:    lanes = {2{wdata[15:0]}};
         default: lanes = wdata;
      endcase
      for (int i = 0; i < int'(LANES); i++) begin
         bit_mask[8*i +: 8] = {8{mask[i]}};
      end
      merge_data_c = (word & ~bit_mask) | (lanes & bit_mask);
      load_data_c  = load_extend(word, funct3, off);
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for a single-port word memory; sub-word stores use read-modify-write.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_funct3,
   input  logic                  req_store,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   lsu_state_t            state_q, state_d;
   lsu_req_t              req_q, req_d;
   logic                  resp_valid_d;
   logic [XLEN-1:0]       resp_rdata_d;
   logic                  resp_err_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_d;
   logic [XLEN-1:0]       mem_wdata_d;
   logic                  misaligned_c, out_of_range_c, illegal_c, req_err_c;
   logic [XLEN-1:0]       load_data_c, merge_data_c;

   assign req_ready = (state_q == IDLE) && !rst;
   // A write already set up for this cycle is suppressed immediately by reset.
   assign mem_we    = mem_we_q && !rst;

   always_comb begin
      misaligned_c   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      out_of_range_c = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
      if (req_store) begin
         illegal_c = req_funct3 > F3_W;
      end else begin
         illegal_c = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111);
      end
      req_err_c = misaligned_c || out_of_range_c || illegal_c;
   end

   lsu_align u_align (
      .word         (mem_rdata),
      .funct3       (req_q.funct3),
      .off          (req_q.off),
      .wdata        (req_q.wdata),
      .load_data_c  (load_data_c),
      .merge_data_c (merge_data_c)
   );

   // Next-state and next-output logic; every output below is registered.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      resp_valid_d = resp_valid;
      resp_rdata_d = resp_rdata;
      resp_err_d   = resp_err;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               req_d = '{store: req_store, funct3: req_funct3,
                         off: req_addr[1:0], wdata: req_wdata};
               if (req_err_c) begin
                  resp_valid_d = 1'b1;
                  resp_rdata_d = '0;
                  resp_err_d   = 1'b1;
                  state_d      = RESP;
               end else begin
                  mem_addr_d = req_addr[ADDR_WIDTH+1:2];
                  if (req_store && (req_funct3 == F3_W)) begin
                     mem_we_d    = 1'b1;
                     mem_wdata_d = req_wdata;
                     state_d     = WRITE;
                  end else begin
                     state_d = READ;
                  end
               end
            end
         end
         READ: begin
            if (req_q.store) begin
               mem_we_d    = 1'b1;
               mem_wdata_d = merge_data_c;
               state_d     = WRITE;
            end else begin
               resp_valid_d = 1'b1;
               resp_rdata_d = load_data_c;
               resp_err_d   = 1'b0;
               state_d      = RESP;
            end
         end
         WRITE: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         req_q      <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         resp_valid <= resp_valid_d;
         resp_rdata <= resp_rdata_d;
         resp_err   <= resp_err_d;
         mem_we_q   <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port with a behavioural memory and response scoreboard.
module tb_lsu_mem_port;

   localparam int unsigned ADDR_WIDTH = 10;
   localparam int unsigned MEM_WORDS  = 1 << ADDR_WIDTH;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  req_valid;
   logic                  req_ready;
   logic [2:0]            req_funct3;
   logic                  req_store;
   logic [31:0]           req_addr;
   logic [31:0]           req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [31:0]           resp_rdata;
   logic                  resp_err;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   logic [31:0]           mem [0:MEM_WORDS-1];
   logic [31:0]           shadow [0:15];
   logic                  init_mem;
   int                    we_cnt = 0;
   logic [ADDR_WIDTH-1:0] last_we_addr;
   logic [31:0]           last_we_data;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_total = 0;
   int   n_pass  = 0;

   always #5 clk = ~clk;

   lsu_mem_port #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_funct3 (req_funct3),
      .req_store  (req_store),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Single-port memory: combinational read, write on posedge.
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
         mem[4] <= 32'h8899AABB;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         we_cnt        <= we_cnt + 1;
         last_we_addr  <= mem_addr;
         last_we_data  <= mem_wdata;
      end
   end

   // Scoreboard: every response handshake is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && resp_valid === 1'b1 && resp_ready === 1'b1) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_resp: got rdata=%h err=%b, required no response", resp_rdata, resp_err);
         end else begin
            mon_e = exp_q.pop_front();
            if (resp_rdata !== mon_e.rdata || resp_err !== mon_e.err)
               $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                        resp_rdata, resp_err, mon_e.rdata, mon_e.err);
            else
               n_pass++;
         end
      end
   end

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
      int o;
      logic [7:0] b0, b1;
      o  = int'(off);
      b0 = w[8*o +: 8];
      b1 = (o < 3) ? w[8*(o+1) +: 8] : 8'h00;
      case (f3)
         3'b000:  return {{24{b0[7]}}, b0};
         3'b100:  return {24'h0, b0};
         3'b001:  return {{16{b1[7]}}, b1, b0};
         3'b101:  return {16'h0, b1, b0};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                             input logic [1:0] off, input logic [31:0] wd);
      logic [31:0] r;
      int o;
      r = old;
      o = int'(off);
      if (f3 == 3'b000) begin
         r[8*o +: 8] = wd[7:0];
      end else if (f3 == 3'b001) begin
         r[8*o +: 8] = wd[7:0];
         if (o < 3) r[8*(o+1) +: 8] = wd[15:8];
      end else begin
         r = wd;
      end
      return r;
   endfunction

   function automatic logic ref_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
      logic ill, mis, oor;
      ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
      oor = a[31:ADDR_WIDTH+2] != '0;
      return ill || mis || oor;
   endfunction

   // Drives one request from posedge+1; returns at the negedge where resp_valid is first seen.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, output int stall, output int lat);
      exp_q.push_back('{rdata: er, err: ee});
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      for (stall = 0; stall < 20; stall++) begin
         @(negedge clk);
         if (req_ready === 1'b1) break;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic complete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      init_mem = 1'b0;
      @(negedge clk);
      n_total++;
      if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b, required 0", req_ready);
      else n_pass++;
      n_total++;
      if ({resp_valid, resp_err, mem_we} !== 3'b000)
         $display("FAIL rst_flags: got valid/err/we=%b, required 000", {resp_valid, resp_err, mem_we});
      else n_pass++;
      n_total++;
      if (resp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h, required 0", resp_rdata);
      else n_pass++;
      n_total++;
      if (mem_addr !== '0 || mem_wdata !== 32'h0)
         $display("FAIL rst_mem_bus: got addr=%h wdata=%h, required 0/0", mem_addr, mem_wdata);
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if (req_ready !== 1'b1) $display("FAIL post_rst_req_ready: got %b, required 1", req_ready);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_load_word();
      int st, lat, w0;
      w0 = we_cnt;
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, st, lat);
      complete();
      n_total++;
      if (lat !== 2) $display("FAIL lw_latency: got %0d, required 2", lat);
      else n_pass++;
      n_total++;
      if (we_cnt !== w0) $display("FAIL lw_no_write: got %0d pulses, required 0", we_cnt - w0);
      else n_pass++;
   endtask

   task automatic test_load_extend();
      logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
      logic [31:0] exps [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
      int st, lat;
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, f3s[i], adrs[i], 32'h0, exps[i], 1'b0, st, lat);
         complete();
         n_total++;
         if (lat !== 2) $display("FAIL ldx_latency[%0d]: got %0d, required 2", i, lat);
         else n_pass++;
      end
   endtask

   task automatic test_sub_store();
      int st, lat, w0;
      w0 = we_cnt;
      issue(1'b1, 3'b000, 32'h11, 32'h12345677, 32'h0, 1'b0, st, lat);
      complete();
      shadow[4] = 32'h889977BB;
      n_total++;
      if (lat !== 3) $display("FAIL sb_latency: got %0d, required 3", lat);
      else n_pass++;
      n_total++;
      if (we_cnt !== w0 + 1) $display("FAIL sb_we_pulses: got %0d, required 1", we_cnt - w0);
      else n_pass++;
      n_total++;
      if (last_we_addr !== 10'd4 || last_we_data !== 32'h889977BB)
         $display("FAIL sb_write: got addr=%0d data=%h, required addr=4 data=889977bb", last_we_addr, last_we_data);
      else n_pass++;
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h889977BB, 1'b0, st, lat);
      complete();
      n_total++;
      if (lat !== 2) $display("FAIL sb_readback_latency: got %0d, required 2", lat);
      else n_pass++;
   endtask

   task automatic test_errors();
      logic        sts  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3s  [4] = '{3'b001, 3'b010, 3'b010, 3'b011};
      logic [31:0] adrs [4] = '{32'h11, 32'h12, 32'h00001000, 32'h10};
      int st, lat, w0;
      for (int i = 0; i < 4; i++) begin
         w0 = we_cnt;
         issue(sts[i], f3s[i], adrs[i], 32'hDEADBEEF, 32'h0, 1'b1, st, lat);
         complete();
         n_total++;
         if (lat !== 1) $display("FAIL err_latency[%0d]: got %0d, required 1", i, lat);
         else n_pass++;
         n_total++;
         if (we_cnt !== w0 || mem[4] !== shadow[4])
            $display("FAIL err_no_write[%0d]: got %0d pulses word4=%h, required 0 pulses word4=%h",
                     i, we_cnt - w0, mem[4], shadow[4]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int st, lat;
      resp_ready = 1'b0;
      issue(1'b0, 3'b010, 32'h10, 32'h0, shadow[4], 1'b0, st, lat);
      n_total++;
      if (lat !== 2) $display("FAIL bp_latency: got %0d, required 2", lat);
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         n_total++;
         if (resp_valid !== 1'b1 || resp_rdata !== shadow[4] || req_ready !== 1'b0)
            $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h req_ready=%b, required 1/%h/0",
                     k, resp_valid, resp_rdata, req_ready, shadow[4]);
         else n_pass++;
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      complete();
      issue(1'b0, 3'b010, 32'h0, 32'h0, shadow[0], 1'b0, st, lat);
      complete();
      n_total++;
      if (st !== 0 || lat !== 2)
         $display("FAIL bp_next_accept: got stall=%0d lat=%0d, required stall=0 lat=2", st, lat);
      else n_pass++;
   endtask

   task automatic test_reset_in_write();
      int st, lat, w0;
      w0         = we_cnt;
      req_valid  = 1'b1;
      req_store  = 1'b1;
      req_funct3 = 3'b001;
      req_addr   = 32'h12;
      req_wdata  = 32'h0000BEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      n_total++;
      if (mem_we !== 1'b1) $display("FAIL rstw_in_write: got mem_we=%b, required 1", mem_we);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (mem_we !== 1'b0 || resp_valid !== 1'b0)
         $display("FAIL rstw_we_forced: got we=%b valid=%b, required 0/0", mem_we, resp_valid);
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || we_cnt !== w0 || mem[4] !== shadow[4])
         $display("FAIL rstw_recover: got ready=%b valid=%b pulses=%0d word4=%h, required 1/0/0/%h",
                  req_ready, resp_valid, we_cnt - w0, mem[4], shadow[4]);
      else n_pass++;
      @(posedge clk);
      #1;
      issue(1'b0, 3'b010, 32'h10, 32'h0, shadow[4], 1'b0, st, lat);
      complete();
      n_total++;
      if (lat !== 2) $display("FAIL rstw_after_latency: got %0d, required 2", lat);
      else n_pass++;
   endtask

   task automatic test_random();
      logic        st_b, e;
      logic [2:0]  f3;
      logic [31:0] a, wd, er;
      logic [3:0]  widx;
      int st, lat, k, exp_lat, bad;
      for (int n = 0; n < 40; n++) begin
         st_b = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            f3 = 3'($urandom_range(0, 7));
         end else if (st_b) begin
            f3 = 3'($urandom_range(0, 2));
         end else begin
            k  = int'($urandom_range(0, 4));
            f3 = (k < 3) ? 3'(k) : 3'(k + 1);
         end
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(12, 31));
         wd   = $urandom;
         e    = ref_err(st_b, f3, a);
         widx = a[5:2];
         er   = 32'h0;
         if (!e && st_b) shadow[widx] = ref_store(shadow[widx], f3, a[1:0], wd);
         else if (!e) er = ref_load(shadow[widx], f3, a[1:0]);
         exp_lat = e ? 1 : (st_b && f3 != 3'b010) ? 3 : 2;
         issue(st_b, f3, a, wd, er, e, st, lat);
         complete();
         n_total++;
         if (lat !== exp_lat)
            $display("FAIL rand_latency[%0d]: got %0d, required %0d (st=%b f3=%0d a=%h)", n, lat, exp_lat, st_b, f3, a);
         else n_pass++;
      end
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== shadow[i]) bad++;
      n_total++;
      if (bad != 0) $display("FAIL rand_mem_image: got %0d differing words, required 0", bad);
      else n_pass++;
   endtask

   initial begin
      init_mem   = 1'b1;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b1;
      for (int i = 0; i < 16; i++) shadow[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
      shadow[4] = 32'h8899AABB;

      test_reset();
      test_load_word();
      test_load_extend();
      test_sub_store();
      test_errors();
      test_backpressure();
      test_reset_in_write();
      test_random();

      repeat (2) @(posedge clk);
      n_total++;
      if (exp_q.size() != 0) $display("FAIL pending_resp: got %0d outstanding, required 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by 500000, required completion");
      $fatal(1);
   end

endmodule
